// File: rtl/systolic_data_setup.sv
// Activation feeder for the 16x16 weight-stationary MMU.
// Accepts one ROWS-lane signed activation vector per cycle and re-emits it
// diagonally skewed (lane i delayed i cycles), then flushes the skew after
// the last vector of a tile and pulses done.
// Optional build macro: SDS_PERF_CNT_EN adds perf_accepted / perf_bubbles.
module systolic_data_setup #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_data,
  input  logic               in_last,
  output logic [ROWS*DW-1:0] ain,
  output logic [ROWS-1:0]    ain_valid,
  output logic               done
`ifdef SDS_PERF_CNT_EN
  ,
  output logic [31:0]        perf_accepted,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam int unsigned CNT_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              done_next;
  logic              accept;

  // Ready is combinational from state and hold so a hold stalls the source at once.
  assign in_ready = !reset && !hold && (state != DRAIN);
  assign accept   = in_valid && in_ready;

  // State, drain counter and done pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // Next-state logic: the drain counter covers the ROWS-1 cycles the deepest lane lags.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            state_next = DRAIN;
            cnt_next   = CNT_W'(ROWS - 1);
          end else begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && in_last) begin
          state_next = DRAIN;
          cnt_next   = CNT_W'(ROWS - 1);
        end
      end
      DRAIN: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Per-lane skew: lane i is an (i+1)-deep shift of {valid, data}; bubbles inject zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DW-1:0] sd [0:i];
    logic          sv [0:i];

    // Unconditional shift every cycle; the array downstream never stalls.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) begin
          sd[s] <= '0;
          sv[s] <= 1'b0;
        end
      end else begin
        sd[0] <= accept ? in_data[i*DW +: DW] : '0;
        sv[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          sd[s] <= sd[s-1];
          sv[s] <= sv[s-1];
        end
      end
    end

    assign ain[i*DW +: DW] = sd[i];
    assign ain_valid[i]    = sv[i];
  end

`ifdef SDS_PERF_CNT_EN
  // Saturating accept and stream-bubble counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_accepted <= '0;
      perf_bubbles  <= '0;
    end else begin
      if (accept && (perf_accepted != 32'hFFFF_FFFF)) begin
        perf_accepted <= perf_accepted + 32'd1;
      end
      if ((state == STREAM) && !accept && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed bench for systolic_data_setup: a cycle table with hand-computed
// ready/done expectations plus an accept-history lookup for the skewed lanes,
// and hand-written sequences for the single-vector, reset-abort corners.
module tb_systolic_data_setup;

  localparam int unsigned ROWS = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned W    = ROWS * DW;
  localparam int          NROW = 43;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic [W-1:0]    ain;
  logic [ROWS-1:0] ain_valid;
  logic            done;
`ifdef SDS_PERF_CNT_EN
  logic [31:0]     perf_accepted;
  logic [31:0]     perf_bubbles;
`endif

  systolic_data_setup #(.ROWS(ROWS), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .ain       (ain),
    .ain_valid (ain_valid),
    .done      (done)
`ifdef SDS_PERF_CNT_EN
    ,
    .perf_accepted (perf_accepted),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       l;
    logic       h;
    logic [7:0] val;
    logic       rdy;
    logic       dn;
  } row_t;

  row_t       tbl [NROW];
  logic       hv  [NROW];
  logic [7:0] hd  [NROW];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input logic v, input logic l, input logic h,
                     input logic [7:0] val, input logic rdy, input logic dn);
    tbl[idx].v   = v;
    tbl[idx].l   = l;
    tbl[idx].h   = h;
    tbl[idx].val = val;
    tbl[idx].rdy = rdy;
    tbl[idx].dn  = dn;
  endtask

  initial begin
    logic [7:0] lane;
    logic [7:0] exp_d;
    logic       exp_v;
    int         idx;

    // Cycle table: index, valid, last, hold, lane value, ready before edge, done after edge.
    for (int r = 0; r < NROW; r++) put(r, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    put(0, 1, 0, 0, 8'h01, 1, 0);
    put(1, 1, 0, 0, 8'h02, 1, 0);
    put(2, 1, 1, 0, 8'h03, 1, 0);
    for (int r = 5; r <= 8; r++) put(r, 0, 0, 1, 8'hAA, 0, 0);
    put(10, 1, 0, 0, 8'hEE, 0, 0);
    put(11, 1, 1, 0, 8'hEE, 0, 0);
    put(17, 0, 0, 0, 8'h00, 0, 1);
    put(18, 1, 0, 0, 8'h07, 1, 0);
    put(19, 1, 0, 0, 8'h07, 1, 0);
    put(20, 0, 0, 0, 8'h55, 1, 0);
    put(21, 1, 0, 0, 8'h07, 1, 0);
    for (int r = 22; r <= 25; r++) put(r, 1, 0, 1, 8'h09, 0, 0);
    put(26, 1, 1, 0, 8'h08, 1, 0);
    put(33, 1, 0, 0, 8'h66, 0, 0);
    put(41, 0, 0, 0, 8'h00, 0, 1);
    put(42, 0, 0, 0, 8'h00, 1, 0);

    // Reset state.
    reset = 1'b1; hold = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #2;
    chk("reset_ain", 64'(ain[63:0]), 64'd0);
    chk("reset_ain_valid", 64'(ain_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    hold = 1'b1;
    #1;
    chk("idle_hold_in_ready", 64'(in_ready), 64'd0);
    hold = 1'b0;
`ifdef SDS_PERF_CNT_EN
    chk("perf_acc_reset", 64'(perf_accepted), 64'd0);
    chk("perf_bub_reset", 64'(perf_bubbles), 64'd0);
`endif
    tick();
    tick();

    // Table run: back-to-back, bubble, hold in STREAM and hold in DRAIN.
    for (int r = 0; r < NROW; r++) begin
      in_valid = tbl[r].v;
      in_last  = tbl[r].l;
      hold     = tbl[r].h;
      in_data  = {ROWS{tbl[r].val}};
      #1;
      chk($sformatf("in_ready row %0d", r), 64'(in_ready), 64'(tbl[r].rdy));
      hv[r] = tbl[r].v & tbl[r].rdy;
      hd[r] = (tbl[r].v & tbl[r].rdy) ? tbl[r].val : 8'h00;
      tick();
      chk($sformatf("done row %0d", r), 64'(done), 64'(tbl[r].dn));
      for (int i = 0; i < int'(ROWS); i++) begin
        idx   = r - i;
        exp_v = (idx >= 0) ? hv[idx] : 1'b0;
        exp_d = (idx >= 0) ? hd[idx] : 8'h00;
        lane  = ain[i*DW +: DW];
        chk($sformatf("ain[%0d] row %0d", i, r), 64'(lane), 64'(exp_d));
        chk($sformatf("ain_valid[%0d] row %0d", i, r), 64'(ain_valid[i]), 64'(exp_v));
      end
      lane = ain[5*DW +: DW];
      if (r == 5) chk("lane5_first", 64'(lane), 64'h01);
      if (r == 6) chk("lane5_second", 64'(lane), 64'h02);
      if (r == 7) chk("lane5_third", 64'(lane), 64'h03);
`ifdef SDS_PERF_CNT_EN
      if (r == 2) chk("perf_acc_three", 64'(perf_accepted), 64'd3);
`endif
    end
`ifdef SDS_PERF_CNT_EN
    chk("perf_acc_total", 64'(perf_accepted), 64'd7);
    chk("perf_bub_total", 64'(perf_bubbles), 64'd5);
`endif
    in_valid = 1'b0; in_last = 1'b0; hold = 1'b0; in_data = '0;
    tick();

    // Single last vector with lane i = -(i+1).
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < int'(ROWS); i++) in_data[i*DW +: DW] = 8'(-(i + 1));
    #1;
    chk("single_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    for (int j = 0; j <= int'(ROWS); j++) begin
      #1;
      chk($sformatf("single done k+%0d", j), 64'(done), 64'(j == int'(ROWS) - 1));
      chk($sformatf("single in_ready k+%0d", j), 64'(in_ready), 64'(j >= int'(ROWS) - 1));
      for (int i = 0; i < int'(ROWS); i++) begin
        lane = ain[i*DW +: DW];
        chk($sformatf("single ain[%0d] k+%0d", i, j), 64'(lane),
            64'((i == j) ? 8'(-(i + 1)) : 8'h00));
        chk($sformatf("single ain_valid[%0d] k+%0d", i, j), 64'(ain_valid[i]), 64'(i == j));
      end
      tick();
    end

    // Reset five cycles into DRAIN aborts the tile with no done.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = {ROWS{8'h11}};
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (5) tick();
    chk("pre_abort_valid", 64'(ain_valid), 64'h0020);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_ain", 64'(ain[63:0]), 64'd0);
    chk("abort_ain_hi", 64'(ain[127:64]), 64'd0);
    chk("abort_ain_valid", 64'(ain_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
`ifdef SDS_PERF_CNT_EN
    chk("abort_perf_acc", 64'(perf_accepted), 64'd0);
    chk("abort_perf_bub", 64'(perf_bubbles), 64'd0);
`endif
    #1;
    reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("abort no done %0d", j), 64'(done), 64'd0);
      chk($sformatf("abort no valid %0d", j), 64'(ain_valid), 64'd0);
    end
    chk("abort_ready_after", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
